// File: rtl/n_packet_tx_ctrl.sv
// Packet buffer and transmit sequencer: collects bytes while idle, then
// strobes each byte and a trailing stop bit into a busy-flagged serial transmitter.
module n_packet_tx_ctrl #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            wr_data,
    input  logic                  wr_strobe,
    input  logic                  send_strobe,
    input  logic                  tx_busy,
    output logic [7:0]            tx_data,
    output logic                  tx_stopbit,
    output logic                  tx_strobe,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  idle,
    output logic                  done,
    output logic                  error
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_BYTE,
        S_SETTLE,
        S_WAIT,
        S_STOP,
        S_STOP_SETTLE,
        S_STOP_WAIT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2:0]   rd_idx;
    logic [7:0]            data_q;
    logic                  full;
    logic                  wr_ok;
    logic                  wr_drop;
    logic                  send_ok;
    logic                  byte_go;
    logic                  stop_go;
    logic                  fin;

    assign full    = (count == FULL);
    assign wr_ok   = wr_strobe && (state == S_IDLE) && !full;
    assign wr_drop = wr_strobe && !wr_ok;
    assign send_ok = send_strobe && (state == S_IDLE);
    assign byte_go = (state == S_BYTE) && !tx_busy;
    assign stop_go = (state == S_STOP) && !tx_busy;
    assign fin     = (state == S_STOP_WAIT) && !tx_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                // A byte written on the send cycle already belongs to the packet
                if (send_strobe) begin
                    state_nx = (count != '0 || wr_ok) ? S_BYTE : S_STOP;
                end
            end
            S_BYTE: begin
                if (!tx_busy) state_nx = S_SETTLE;
            end
            S_SETTLE: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (!tx_busy) begin
                    state_nx = (rd_idx < count) ? S_BYTE : S_STOP;
                end
            end
            S_STOP: begin
                if (!tx_busy) state_nx = S_STOP_SETTLE;
            end
            S_STOP_SETTLE: begin
                state_nx = S_STOP_WAIT;
            end
            S_STOP_WAIT: begin
                if (!tx_busy) state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        tx_strobe  = byte_go || stop_go;
        tx_stopbit = stop_go;
        tx_data    = (state == S_BYTE) ? mem[rd_idx[DEPTH_LOG2-1:0]] : data_q;
        idle       = (state == S_IDLE);
        done       = fin;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            rd_idx <= '0;
            data_q <= 8'h00;
            error  <= 1'b0;
        end else begin
            error <= wr_drop;
            if (fin) begin
                count <= '0;
            end else if (wr_ok) begin
                count <= count + 1'b1;
            end
            if (send_ok) begin
                rd_idx <= '0;
            end else if (byte_go) begin
                rd_idx <= rd_idx + 1'b1;
            end
            if (byte_go) begin
                data_q <= mem[rd_idx[DEPTH_LOG2-1:0]];
            end
        end
    end

    // Storage is qualified by count, so it needs no reset
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[count[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_n_packet_tx_ctrl.sv
// Directed bench for n_packet_tx_ctrl with a transmitter model that
// holds busy for 5 cycles after every strobe.
module tb_n_packet_tx_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_strobe = 1'b0;
    logic       send_strobe = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_stopbit;
    logic       tx_strobe;
    logic [3:0] count;
    logic       idle;
    logic       done;
    logic       error;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int bad_stop = 0;
    int bcnt = 0;
    logic [8:0] log_q [$];

    n_packet_tx_ctrl #(.DEPTH_LOG2(3)) dut (
        .clk(clk),
        .reset(reset),
        .wr_data(wr_data),
        .wr_strobe(wr_strobe),
        .send_strobe(send_strobe),
        .tx_busy(tx_busy),
        .tx_data(tx_data),
        .tx_stopbit(tx_stopbit),
        .tx_strobe(tx_strobe),
        .count(count),
        .idle(idle),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Output monitor and transmitter busy model
    initial begin
        logic pend;
        forever begin
            @(negedge clk);
            pend = tx_strobe;
            if (tx_strobe) log_q.push_back(tx_stopbit ? 9'h100 : {1'b0, tx_data});
            if (done) done_cnt++;
            if (error) err_cnt++;
            if (tx_stopbit && !tx_strobe) bad_stop++;
            @(posedge clk);
            #1;
            if (reset) bcnt = 0;
            else if (pend) bcnt = 5;
            else if (bcnt > 0) bcnt--;
            tx_busy = (bcnt != 0);
        end
    end

    task automatic wr(input logic [7:0] d);
        wr_data = d;
        wr_strobe = 1'b1;
        @(negedge clk);
        wr_strobe = 1'b0;
    endtask

    task automatic send();
        send_strobe = 1'b1;
        @(negedge clk);
        send_strobe = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target);
        int n = 0;
        while (done_cnt < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done_cnt, target);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_strobe(input string tag);
        int n = 0;
        while (!tx_strobe && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, tx_strobe, 1);
    endtask

    task automatic clear();
        log_q.delete();
        done_cnt = 0;
        err_cnt = 0;
    endtask

    initial begin
        #2;
        chk("rst_idle", idle, 1);
        chk("rst_count", count, 0);
        chk("rst_strobe", tx_strobe, 0);
        chk("rst_stop", tx_stopbit, 0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_done", done, 0);
        chk("rst_err", error, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // two-byte packet, first strobe one cycle after send
        clear();
        wr(8'h01);
        wr(8'h02);
        chk("t1_count", count, 2);
        send_strobe = 1'b1;
        @(negedge clk);
        send_strobe = 1'b0;
        chk("t1_lat", tx_strobe, 1);
        chk("t1_lat_d", tx_data, 8'h01);
        chk("t1_idle0", idle, 0);
        wait_done("t1_done", 1);
        chk("t1_n", log_q.size(), 3);
        chk("t1_b0", log_q[0], 9'h001);
        chk("t1_b1", log_q[1], 9'h002);
        chk("t1_b2", log_q[2], 9'h100);
        chk("t1_done1", done_cnt, 1);
        chk("t1_count0", count, 0);
        chk("t1_idle", idle, 1);
        chk("t1_hold", tx_data, 8'h02);

        // empty packet: stop bit only
        clear();
        send();
        wait_done("t2_done", 1);
        chk("t2_n", log_q.size(), 1);
        chk("t2_b0", log_q[0], 9'h100);

        // overfill: 9th byte dropped
        clear();
        for (int i = 0; i < 9; i++) wr(8'h10 + 8'(i));
        @(negedge clk);
        chk("t3_count", count, 8);
        chk("t3_err", err_cnt, 1);
        send();
        wait_done("t3_done", 1);
        chk("t3_n", log_q.size(), 9);
        for (int i = 0; i < 8; i++) chk("t3_b", log_q[i], 9'h010 + 9'(i));
        chk("t3_stop", log_q[8], 9'h100);

        // write during S_WAIT is dropped
        clear();
        wr(8'hA0);
        wr(8'hA1);
        wr(8'hA2);
        send();
        wait_strobe("t4_s0");
        @(negedge clk);
        @(negedge clk);
        wr(8'h55);
        @(negedge clk);
        chk("t4_err", err_cnt, 1);
        chk("t4_count", count, 3);
        wait_done("t4_done", 1);
        chk("t4_n", log_q.size(), 4);
        chk("t4_b0", log_q[0], 9'h0A0);
        chk("t4_b1", log_q[1], 9'h0A1);
        chk("t4_b2", log_q[2], 9'h0A2);
        chk("t4_b3", log_q[3], 9'h100);

        // reset in S_WAIT of byte 2 of 3
        clear();
        wr(8'hB0);
        wr(8'hB1);
        wr(8'hB2);
        send();
        wait_strobe("t5_s0");
        @(negedge clk);
        wait_strobe("t5_s1");
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_strobe", tx_strobe, 0);
        chk("t5_stop", tx_stopbit, 0);
        chk("t5_data", tx_data, 8'h00);
        chk("t5_count", count, 0);
        chk("t5_idle", idle, 1);
        chk("t5_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("t5_idle2", idle, 1);
        chk("t5_n", log_q.size(), 2);
        chk("t5_nodone", done_cnt, 0);

        // same-cycle write and send on an empty buffer
        clear();
        wr_data = 8'hAA;
        wr_strobe = 1'b1;
        send_strobe = 1'b1;
        @(negedge clk);
        wr_strobe = 1'b0;
        send_strobe = 1'b0;
        wait_done("t6_done", 1);
        chk("t6_n", log_q.size(), 2);
        chk("t6_b0", log_q[0], 9'h0AA);
        chk("t6_b1", log_q[1], 9'h100);
        chk("t6_err", err_cnt, 0);

        chk("stop_wo_strobe", bad_stop, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/n_packet_tx_ctrl.md
N_PACKET_TX_CTRL -- requirements
Module: n_packet_tx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3, meaning the packet buffer holds 2^DEPTH_LOG2 bytes (8).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port wr_data  input  8  byte to append to the packet buffer.
REQ-005 SHALL have port wr_strobe  input  1  one-cycle pulse; appends wr_data.
REQ-006 SHALL have port send_strobe  input  1  one-cycle pulse; commits the buffered bytes as one packet.
REQ-007 SHALL have port tx_busy  input  1  busy flag from the serial transmitter.
REQ-008 SHALL have port tx_data  output  8  byte presented to the transmitter.
REQ-009 SHALL have port tx_stopbit  output  1  qualifies tx_strobe as a stop-bit request.
REQ-010 SHALL have port tx_strobe  output  1  one-cycle start pulse to the transmitter.
REQ-011 SHALL have port count  output  DEPTH_LOG2+1  number of bytes currently buffered.
REQ-012 SHALL have port idle  output  1  high only in S_IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a packet's stop bit has finished.
REQ-014 SHALL have port error  output  1  one-cycle pulse when a write is dropped.

Function
REQ-015 SHALL implement states S_IDLE, S_BYTE, S_SETTLE, S_WAIT, S_STOP, S_STOP_SETTLE, S_STOP_WAIT.
REQ-016 In S_IDLE, wr_strobe with count < 2^DEPTH_LOG2 SHALL store wr_data at index count and increment count on the same edge.
REQ-017 wr_strobe with count == 2^DEPTH_LOG2, or in any state other than S_IDLE, SHALL drop the byte, leave count unchanged and pulse error on the next cycle.
REQ-018 send_strobe in S_IDLE SHALL reset the read index to 0 and move to S_BYTE if count > 0, or to S_STOP if count == 0 (stop-bit-only packet).
REQ-019 Simultaneous wr_strobe and send_strobe in S_IDLE SHALL accept the byte first; that byte is part of the packet.
REQ-020 send_strobe outside S_IDLE SHALL be ignored, with no error pulse.
REQ-021 S_BYTE, entered with tx_busy low: SHALL drive tx_data = buffer[read index], tx_stopbit = 0, tx_strobe = 1 for exactly one cycle, increment the read index, and go to S_SETTLE.
REQ-022 If tx_busy is high on entry to S_BYTE or S_STOP, the FSM SHALL hold with tx_strobe low until tx_busy is low.
REQ-023 S_SETTLE SHALL last one cycle with tx_strobe = 0, so the transmitter can raise busy, then go to S_WAIT.
REQ-024 S_WAIT SHALL stay while tx_busy = 1; on tx_busy = 0 it SHALL go to S_BYTE if read index < count, else to S_STOP.
REQ-025 S_STOP SHALL drive tx_stopbit = 1 and tx_strobe = 1 for one cycle, then go to S_STOP_SETTLE (one cycle), then S_STOP_WAIT.
REQ-026 S_STOP_WAIT on tx_busy = 0 SHALL pulse done for one cycle, clear count to 0, and return to S_IDLE.
REQ-027 tx_stopbit SHALL be 0 whenever tx_strobe is 0.
REQ-028 tx_data SHALL hold its last value outside S_BYTE.
REQ-029 Latency: first tx_strobe SHALL occur 1 cycle after send_strobe, given tx_busy low.
REQ-030 Consecutive byte strobes SHALL be at least 3 cycles apart.
REQ-031 The buffer SHALL not wrap: the read index never exceeds count; the write index is count.

Reset
REQ-032 Asserting reset SHALL immediately force S_IDLE, count = 0, read index = 0, tx_data = 8'h00, and tx_strobe = tx_stopbit = done = error = 0.
REQ-033 Asserting reset mid-packet SHALL abandon the packet with no stop bit issued.
REQ-034 Buffer contents SHALL need no reset.

Verification
REQ-035 Write 8'h01 and 8'h02, then send_strobe, with tx_busy modelled high for 5 cycles after each strobe -> tx_strobe with data 01, then with data 02, then a stop-bit strobe; then done pulses once, count = 0, idle = 1.
REQ-036 send_strobe with count = 0 -> a single tx_strobe with tx_stopbit = 1, then done.
REQ-037 Write 9 bytes 8'h10 to 8'h18 while idle -> count = 8 and error pulses once on the 9th; the packet sends 10 to 17.
REQ-038 wr_strobe during S_WAIT -> error pulse, count unchanged, packet unaltered.
REQ-039 Assert reset while in S_WAIT of byte 2 of 3 -> all outputs at reset values the same cycle, idle = 1 after release, no further tx_strobe.
REQ-040 Same-cycle wr_strobe(8'hAA) and send_strobe with count = 0 -> one data strobe with AA, then a stop strobe.
